// File: rtl/sd_cmd_frame_assembler.sv
// SD command frame assembler: hunts for a start byte in the SPI receive stream,
// collects the 6-byte command frame, checks CRC7 and presents the decoded command.
module sd_cmd_frame_assembler #(
  parameter bit CRC_ENABLE  = 1'b1,
  parameter int FRAME_BYTES = 6
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        CS,
  input  logic [7:0]  Buffer,
  input  logic        Changed,
  input  logic        Hold,
  output logic [5:0]  CmdIndex,
  output logic [31:0] CmdArg,
  output logic [6:0]  CmdCrc,
  output logic        CrcOk,
  output logic        CmdValid,
  output logic        FrameError,
  output logic        Busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  // Counter value at which the stop/CRC byte is expected.
  localparam logic [2:0] LAST_CNT = 3'(FRAME_BYTES - 1);

  // CRC7 (x^7 + x^3 + 1), one byte MSB first, unrolled into eight bit steps.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[6] ^ data[i];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [6:0]  crc_r, crc_s;
  logic [5:0]  idx_sh_r, idx_sh_s;
  logic [31:0] arg_sh_r, arg_sh_s;
  logic [5:0]  cmd_index_s;
  logic [31:0] cmd_arg_s;
  logic [6:0]  cmd_crc_s;
  logic        crc_ok_s;
  logic        cmd_valid_s;
  logic        frame_error_s;
  logic        accept_s;

  // State, shadow and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      crc_r      <= 7'd0;
      idx_sh_r   <= 6'd0;
      arg_sh_r   <= 32'd0;
      CmdIndex   <= 6'd0;
      CmdArg     <= 32'd0;
      CmdCrc     <= 7'd0;
      CrcOk      <= 1'b0;
      CmdValid   <= 1'b0;
      FrameError <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      crc_r      <= crc_s;
      idx_sh_r   <= idx_sh_s;
      arg_sh_r   <= arg_sh_s;
      CmdIndex   <= cmd_index_s;
      CmdArg     <= cmd_arg_s;
      CmdCrc     <= cmd_crc_s;
      CrcOk      <= crc_ok_s;
      CmdValid   <= cmd_valid_s;
      FrameError <= frame_error_s;
      Busy       <= (state_s == COLLECT);
    end
  end

  // Next-state and frame-assembly logic.
  always_comb begin
    accept_s      = Changed && !CS && !Hold;
    state_s       = state_r;
    cnt_s         = cnt_r;
    crc_s         = crc_r;
    idx_sh_s      = idx_sh_r;
    arg_sh_s      = arg_sh_r;
    cmd_index_s   = CmdIndex;
    cmd_arg_s     = CmdArg;
    cmd_crc_s     = CmdCrc;
    crc_ok_s      = CrcOk;
    cmd_valid_s   = 1'b0;
    frame_error_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (Buffer[7:6] == 2'b01)) begin
          idx_sh_s = Buffer[5:0];
          crc_s    = crc7_byte(7'd0, Buffer);
          cnt_s    = 3'd1;
          state_s  = COLLECT;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if (CS) begin
          // Chip select released mid-frame: drop the frame silently.
          state_s = IDLE;
          cnt_s   = 3'd0;
        end else if (accept_s) begin
          if (cnt_r == LAST_CNT) begin
            state_s = IDLE;
            cnt_s   = 3'd0;
            if (Buffer[0]) begin
              cmd_valid_s = 1'b1;
              cmd_index_s = idx_sh_r;
              cmd_arg_s   = arg_sh_r;
              cmd_crc_s   = Buffer[7:1];
              crc_ok_s    = CRC_ENABLE ? (crc_r == Buffer[7:1]) : 1'b1;
            end else begin
              frame_error_s = 1'b1;
            end
          end else begin
            arg_sh_s = {arg_sh_r[23:0], Buffer};
            crc_s    = crc7_byte(crc_r, Buffer);
            cnt_s    = cnt_r + 3'd1;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

endmodule
